// File: rtl/mania_playfield.sv
// Four-lane falling-note playfield: note slots, per-frame scroll, key judging and the
// registered RGB444 pixel for vgac. Define MANIA_COMBO_EN to build the combo counter.
module mania_playfield #(
  parameter int N_NOTES    = 4,
  parameter int SPEED      = 4,
  parameter int JUDGE_ROW  = 420,
  parameter int HIT_WINDOW = 16,
  parameter int NOTE_H     = 12,
  parameter int LANE_X0    = 240,
  parameter int LANE_W     = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        rdn,
  input  logic [3:0]  key,
  input  logic        spawn_valid,
  input  logic [1:0]  spawn_lane,
  output logic        spawn_ready,
  output logic [11:0] d_in,
  output logic [3:0]  hit_pulse,
  output logic [3:0]  miss_pulse,
  output logic [15:0] score,
  output logic [9:0]  combo
);

  localparam int SW = (N_NOTES > 1) ? $clog2(N_NOTES) : 1;
  localparam logic [10:0] WIN_LO  = 11'(JUDGE_ROW - HIT_WINDOW);
  localparam logic [10:0] WIN_HI  = 11'(JUDGE_ROW + HIT_WINDOW);
  localparam logic [10:0] HALF_H  = 11'(NOTE_H / 2);
  localparam logic [10:0] JUDGE_V = 11'(JUDGE_ROW);
  localparam logic [9:0]  SPEED_V = 10'(SPEED);

  logic [N_NOTES-1:0] valid_r [4];
  logic [9:0]         y_r     [4][N_NOTES];
  logic [N_NOTES-1:0] valid_n_s [4];
  logic [9:0]         y_n_s     [4][N_NOTES];

  logic [8:0]  row_q_r;
  logic        update_r;
  logic        ready_en_r;
  logic [3:0]  key_q_r;
  logic [3:0]  pending_r;
  logic [11:0] d_in_r;
  logic [3:0]  hit_r;
  logic [3:0]  miss_r;
  logic [15:0] score_r;

  logic        frame_start_s;
  logic [3:0]  rise_s;
  logic [3:0]  lane_free_s;
  logic [3:0]  pend_n_s;
  logic [3:0]  hit_n_s;
  logic [3:0]  miss_n_s;
  logic [9:0]  ny_s;
  logic        found_s;
  logic [SW-1:0] best_s;
  logic [SW-1:0] spawn_slot_s;
  logic [16:0] score_sum_s;
  logic [15:0] score_n_s;
  logic [11:0] pix_s;
  logic        in_lane_s;
  logic        note_px_s;
  logic        key_px_s;
  logic        edge_px_s;
  logic [10:0] row_ext_s;
  logic [10:0] col_ext_s;

  assign frame_start_s = (row_addr == 9'd0) && (row_q_r != 9'd0);
  assign rise_s        = key & ~key_q_r;
  always_comb begin
    for (int k = 0; k < 4; k++) lane_free_s[k] = ~&valid_r[k];
  end
  assign spawn_ready = ready_en_r & lane_free_s[spawn_lane] & ~update_r;

  assign d_in       = d_in_r;
  assign hit_pulse  = hit_r;
  assign miss_pulse = miss_r;
  assign score      = score_r;

  // Slot next state: scroll on update cycles, otherwise judge pending keys; spawn uses pre-hit free slots.
  always_comb begin
    valid_n_s    = valid_r;
    y_n_s        = y_r;
    pend_n_s     = pending_r | rise_s;
    hit_n_s      = 4'b0000;
    miss_n_s     = 4'b0000;
    ny_s         = 10'd0;
    found_s      = 1'b0;
    best_s       = '0;
    spawn_slot_s = '0;
    if (update_r) begin
      for (int k = 0; k < 4; k++) begin
        for (int s = 0; s < N_NOTES; s++) begin
          ny_s = y_r[k][s] + SPEED_V;
          if (valid_r[k][s] && ({1'b0, ny_s} > WIN_HI)) begin
            valid_n_s[k][s] = 1'b0;
            miss_n_s[k]     = 1'b1;
          end else if (valid_r[k][s]) begin
            y_n_s[k][s] = ny_s;
          end else begin
            y_n_s[k][s] = y_r[k][s];
          end
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        found_s = 1'b0;
        best_s  = '0;
        for (int s = 0; s < N_NOTES; s++) begin
          if (valid_r[k][s] && ({1'b0, y_r[k][s]} >= WIN_LO) && ({1'b0, y_r[k][s]} <= WIN_HI)
              && (!found_s || (y_r[k][s] > y_r[k][best_s]))) begin
            found_s = 1'b1;
            best_s  = SW'(s);
          end else begin
            found_s = found_s;
          end
        end
        if (pend_n_s[k]) begin
          pend_n_s[k] = 1'b0;
          if (found_s) begin
            valid_n_s[k][best_s] = 1'b0;
            hit_n_s[k]           = 1'b1;
          end else begin
            hit_n_s[k] = 1'b0;
          end
        end else begin
          hit_n_s[k] = 1'b0;
        end
      end
    end
    for (int s = N_NOTES - 1; s >= 0; s--) begin
      if (!valid_r[spawn_lane][s]) spawn_slot_s = SW'(s);
      else spawn_slot_s = spawn_slot_s;
    end
    if (spawn_valid && spawn_ready) begin
      valid_n_s[spawn_lane][spawn_slot_s] = 1'b1;
      y_n_s[spawn_lane][spawn_slot_s]     = 10'd0;
    end else begin
      spawn_slot_s = spawn_slot_s;
    end
    score_sum_s = {1'b0, score_r} + 17'($countones(hit_n_s));
    if (score_sum_s[16]) score_n_s = 16'hFFFF;
    else score_n_s = score_sum_s[15:0];
  end

  // Pixel colour for the current row/column, in priority order.
  always_comb begin
    pix_s     = 12'h223;
    in_lane_s = 1'b0;
    note_px_s = 1'b0;
    key_px_s  = 1'b0;
    edge_px_s = 1'b0;
    row_ext_s = {2'b00, row_addr};
    col_ext_s = {1'b0, col_addr};
    for (int k = 0; k < 4; k++) begin
      if ((col_ext_s >= 11'(LANE_X0 + k * LANE_W)) && (col_ext_s < 11'(LANE_X0 + (k + 1) * LANE_W))) begin
        in_lane_s = 1'b1;
        key_px_s  = key[k];
        for (int s = 0; s < N_NOTES; s++) begin
          if (valid_r[k][s] && (row_ext_s + HALF_H > {1'b0, y_r[k][s]})
              && ({1'b0, y_r[k][s]} + HALF_H > row_ext_s)) note_px_s = 1'b1;
          else note_px_s = note_px_s;
        end
      end else begin
        in_lane_s = in_lane_s;
      end
    end
    for (int k = 0; k <= 4; k++) begin
      if (col_ext_s == 11'(LANE_X0 + k * LANE_W)) edge_px_s = 1'b1;
      else edge_px_s = edge_px_s;
    end
    if (rdn) pix_s = 12'h000;
    else if (note_px_s) pix_s = 12'hF80;
    else if (in_lane_s && (row_ext_s == JUDGE_V)) pix_s = 12'hFFF;
    else if (key_px_s) pix_s = 12'h446;
    else if (edge_px_s) pix_s = 12'h888;
    else pix_s = 12'h223;
  end

  // State, pulse and pixel registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        valid_r[k] <= '0;
        for (int s = 0; s < N_NOTES; s++) y_r[k][s] <= 10'd0;
      end
      row_q_r    <= 9'd0;
      update_r   <= 1'b0;
      ready_en_r <= 1'b0;
      key_q_r    <= 4'b0000;
      pending_r  <= 4'b0000;
      d_in_r     <= 12'h000;
      hit_r      <= 4'b0000;
      miss_r     <= 4'b0000;
      score_r    <= 16'd0;
    end else begin
      valid_r    <= valid_n_s;
      y_r        <= y_n_s;
      row_q_r    <= row_addr;
      update_r   <= frame_start_s;
      ready_en_r <= 1'b1;
      key_q_r    <= key;
      pending_r  <= pend_n_s;
      d_in_r     <= pix_s;
      hit_r      <= hit_n_s;
      miss_r     <= miss_n_s;
      score_r    <= score_n_s;
    end
  end

`ifdef MANIA_COMBO_EN
  logic [9:0]  combo_r;
  logic [10:0] combo_sum_s;
  logic [9:0]  combo_n_s;

  // Combo grows per hit, saturates, and any miss in the cycle wins.
  always_comb begin
    combo_sum_s = {1'b0, combo_r} + 11'($countones(hit_n_s));
    if (miss_n_s != 4'b0000) combo_n_s = 10'd0;
    else if (combo_sum_s > 11'd1023) combo_n_s = 10'd1023;
    else combo_n_s = combo_sum_s[9:0];
  end

  // Combo register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) combo_r <= 10'd0;
    else combo_r <= combo_n_s;
  end

  assign combo = combo_r;
`else
  assign combo = 10'd0;
`endif

endmodule

// File: tb/tb_mania_playfield.sv
// Self-checking bench for mania_playfield: directed scenarios plus random traffic against a
// slot-list reference model built from the playfield rules.
module tb_mania_playfield;

  logic        clk;
  logic        rst;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic [3:0]  key;
  logic        spawn_valid;
  logic [1:0]  spawn_lane;
  logic        spawn_ready;
  logic [11:0] d_in;
  logic [3:0]  hit_pulse;
  logic [3:0]  miss_pulse;
  logic [15:0] score;
  logic [9:0]  combo;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model
  bit       mv [4][4];
  int       my [4][4];
  int       mscore, mcombo, mprev_row;
  bit [3:0] mpend, mkey_prev;
  bit       mupd, mready;

  mania_playfield dut (
    .clk(clk), .rst(rst), .row_addr(row_addr), .col_addr(col_addr), .rdn(rdn), .key(key),
    .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready), .d_in(d_in),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score), .combo(combo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lane_count(input int l);
    int n = 0;
    for (int s = 0; s < 4; s++) if (mv[l][s]) n++;
    return n;
  endfunction

  function automatic logic [11:0] model_pix(input int r, input int c, input bit rd, input bit [3:0] kv);
    int ln = -1;
    if (c >= 240 && c < 400) ln = (c - 240) / 40;
    if (rd) return 12'h000;
    if (ln >= 0)
      for (int s = 0; s < 4; s++)
        if (mv[ln][s] && (r - my[ln][s] < 6) && (my[ln][s] - r < 6)) return 12'hF80;
    if (ln >= 0 && r == 420) return 12'hFFF;
    if (ln >= 0 && kv[ln]) return 12'h446;
    if (c >= 240 && c <= 400 && ((c - 240) % 40) == 0) return 12'h888;
    return 12'h223;
  endfunction

  // One clock cycle with the inputs currently driven; model advanced, outputs checked after the edge.
  task automatic step();
    logic [11:0] ep;
    bit [3:0] rises, p, eh, em;
    bit er, nupd;
    int sl, best, nh, ln;
    ep = model_pix(int'(row_addr), int'(col_addr), rdn, key);
    ln = int'(spawn_lane);
    er = mready && !mupd && (lane_count(ln) < 4);
    #1;
    chk("spawn_ready", {15'd0, spawn_ready}, {15'd0, er});
    rises = key & ~mkey_prev;
    nupd  = (row_addr == 9'd0) && (mprev_row != 0);
    eh = 4'b0; em = 4'b0; sl = -1;
    if (spawn_valid && er)
      for (int s = 0; s < 4; s++) if (!mv[ln][s] && sl < 0) sl = s;
    if (mupd) begin
      mpend = mpend | rises;
      for (int k = 0; k < 4; k++)
        for (int s = 0; s < 4; s++)
          if (mv[k][s]) begin
            my[k][s] += 4;
            if (my[k][s] > 436) begin mv[k][s] = 1'b0; em[k] = 1'b1; end
          end
    end else begin
      p = mpend | rises;
      mpend = 4'b0;
      for (int k = 0; k < 4; k++) if (p[k]) begin
        best = -1;
        for (int s = 0; s < 4; s++)
          if (mv[k][s] && my[k][s] >= 404 && my[k][s] <= 436 && (best < 0 || my[k][s] > my[k][best])) best = s;
        if (best >= 0) begin mv[k][best] = 1'b0; eh[k] = 1'b1; end
      end
    end
    if (sl >= 0) begin mv[ln][sl] = 1'b1; my[ln][sl] = 0; end
    nh = $countones(eh);
    mscore = (mscore + nh > 65535) ? 65535 : mscore + nh;
`ifdef MANIA_COMBO_EN
    if (em != 4'b0) mcombo = 0;
    else mcombo = (mcombo + nh > 1023) ? 1023 : mcombo + nh;
`endif
    mkey_prev = key; mprev_row = int'(row_addr); mupd = nupd; mready = 1'b1;
    @(posedge clk); #1;
    chk("d_in", {4'd0, d_in}, {4'd0, ep});
    chk("hit_pulse", {12'd0, hit_pulse}, {12'd0, eh});
    chk("miss_pulse", {12'd0, miss_pulse}, {12'd0, em});
    chk("score", score, 16'(mscore));
    chk("combo", {6'd0, combo}, 16'(mcombo));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_d_in", {4'd0, d_in}, 16'd0);
    chk("rst_pulses", {8'd0, hit_pulse, miss_pulse}, 16'd0);
    chk("rst_score", score, 16'd0);
    chk("rst_combo", {6'd0, combo}, 16'd0);
    @(posedge clk); #1;
    chk("rst_ready", {15'd0, spawn_ready}, 16'd0);
    for (int k = 0; k < 4; k++) for (int s = 0; s < 4; s++) begin mv[k][s] = 1'b0; my[k][s] = 0; end
    mscore = 0; mcombo = 0; mprev_row = 0; mpend = 4'b0; mkey_prev = 4'b0; mupd = 1'b0; mready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic spawn(input int l);
    spawn_valid = 1'b1; spawn_lane = 2'(l);
    step();
    spawn_valid = 1'b0;
  endtask

  task automatic frame(input bit sp, input bit [3:0] kv);
    row_addr = 9'd0;
    step();
    row_addr = 9'd1; spawn_valid = sp; spawn_lane = 2'($urandom_range(0, 3)); key = key | kv;
    step();
    spawn_valid = 1'b0;
    if (kv != 4'b0) begin step(); key = 4'b0; step(); end
  endtask

  task automatic press(input int l);
    key = key | (4'b0001 << l);
    step();
    key = 4'b0;
    step();
  endtask

  task automatic pix(input int r, input int c, input bit rd, input bit [3:0] kv);
    row_addr = 9'(r); col_addr = 10'(c); rdn = rd; key = kv;
    step();
    row_addr = 9'd1; rdn = 1'b1; key = 4'b0;
  endtask

  initial begin
    rst = 1'b1; row_addr = 9'd1; col_addr = 10'd0; rdn = 1'b1; key = 4'b0;
    spawn_valid = 1'b0; spawn_lane = 2'd0;
    @(posedge clk); #1;
    do_reset();
    step();
    step();

    // judge exactly at the line
    spawn(2);
    repeat (105) frame(1'b0, 4'b0);
    pix(420, 330, 1'b0, 4'b0);
    press(2);
    pix(420, 330, 1'b0, 4'b0);

    // note falls through the window
    spawn(0);
    repeat (110) frame(1'b0, 4'b0);

    // full lane, and ready dropped during update cycles
    repeat (5) spawn(0);
    spawn(1);
    repeat (3) frame(1'b1, 4'b0);

    // rendering
    repeat (22) frame(1'b0, 4'b0);
    pix(100, 285, 1'b0, 4'b0);
    pix(100, 285, 1'b1, 4'b0);
    pix(420, 250, 1'b0, 4'b0);
    pix(300, 240, 1'b0, 4'b0);
    pix(300, 100, 1'b0, 4'b0);
    pix(300, 330, 1'b0, 4'b0100);
    pix(300, 400, 1'b0, 4'b0);

    // key edge during the update cycle, two notes in the window
    spawn(3);
    repeat (4) frame(1'b0, 4'b0);
    spawn(3);
    repeat (101) frame(1'b0, 4'b0);
    frame(1'b0, 4'b1000);
    press(3);

    // random traffic
    repeat (400) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: frame(1'($urandom_range(0, 1)),
                             ($urandom_range(0, 7) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0);
        5, 6: spawn(int'($urandom_range(0, 3)));
        7: press(int'($urandom_range(0, 3)));
        default: pix(int'($urandom_range(1, 479)), int'($urandom_range(0, 639)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)));
      endcase
    end

    // reset in the middle of a frame with live notes
    repeat (6) spawn(int'($urandom_range(0, 3)));
    frame(1'b0, 4'b0);
    row_addr = 9'd0;
    step();
    do_reset();
    row_addr = 9'd1;
    step();
    repeat (3) frame(1'b0, 4'b0);

    // three hits then a miss (combo 1,2,3,0 when enabled)
    repeat (4) spawn(0);
    repeat (102) frame(1'b0, 4'b0);
    repeat (3) press(0);
    repeat (8) frame(1'b0, 4'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
